// File: rtl/led_blink_sequencer_if.sv
// Control/status bundle between a sequencer owner and led_blink_sequencer.
// The sequencer side is the slave; whoever loads patterns is the master.
interface led_blink_sequencer_if;
  logic       i_start;
  logic       i_stop;
  logic       i_loop;
  logic [7:0] i_pattern;
  logic       o_enable;
  logic       o_switch_1;
  logic       o_switch_2;
  logic [1:0] o_step;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_start, i_stop, i_loop, i_pattern,
    input  o_enable, o_switch_1, o_switch_2,
    input  o_step, o_busy, o_done
  );

  modport slave (
    input  i_start, i_stop, i_loop, i_pattern,
    output o_enable, o_switch_1, o_switch_2,
    output o_step, o_busy, o_done
  );
endinterface

// File: rtl/led_blink_sequencer.sv
// Four-step blink-rate sequencer feeding led_blinker controls,
// with optional blank gaps between steps and loop/one-shot modes.
module led_blink_sequencer #(
  parameter int DWELL = 1000,
  parameter int GAP   = 2
) (
  input logic                  i_clock,
  input logic                  i_reset,
  led_blink_sequencer_if.slave bus
);

  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST =
    (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    step, step_n;
  logic [7:0]    pat, pat_n;
  logic          enable, enable_n;
  logic [1:0]    sw, sw_n;
  logic          busy, busy_n;
  logic          done, done_n;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      step   <= '0;
      pat    <= '0;
      enable <= 1'b0;
      sw     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      step   <= step_n;
      pat    <= pat_n;
      enable <= enable_n;
      sw     <= sw_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    step_n  = step;
    pat_n   = pat;
    unique case (state)
      S_IDLE: begin
        if (bus.i_start && !bus.i_stop) begin
          state_n = S_RUN;
          step_n  = 2'd0;
          pat_n   = bus.i_pattern;
        end
      end
      S_RUN: begin
        if (bus.i_stop) begin
          state_n = S_IDLE;
        end else if (cnt != DWELL_LAST) begin
          cnt_n = cnt + 1'b1;
        end else if (step == 2'd3 && !bus.i_loop) begin
          state_n = S_DONE;
        end else if (GAP == 0) begin
          // back-to-back steps: stay in RUN, new step
          step_n = step + 1'b1;
        end else begin
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (bus.i_stop) begin
          state_n = S_IDLE;
        end else if (cnt != GAP_LAST) begin
          cnt_n = cnt + 1'b1;
        end else begin
          state_n = S_RUN;
          step_n  = step + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    enable_n = (state_n == S_RUN);
    busy_n   = (state_n == S_RUN) ||
               (state_n == S_GAP);
    done_n   = (state_n == S_DONE);
    sw_n     = sw;
    if (state_n == S_RUN) begin
      sw_n = pat_n[{step_n, 1'b0} +: 2];
    end
  end

  assign bus.o_enable   = enable;
  assign bus.o_switch_1 = sw[1];
  assign bus.o_switch_2 = sw[0];
  assign bus.o_step     = step;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench: two sequencers (10/2 and 1/0) against a timeline model
// that derives outputs from elapsed cycles since start.
module tb_led_blink_sequencer;

  logic clk = 1'b0;
  logic rs  = 1'b1;
  always #5 clk = ~clk;

  led_blink_sequencer_if ifa ();
  led_blink_sequencer_if ifb ();

  led_blink_sequencer #(
    .DWELL(10),
    .GAP  (2)
  ) dut_a (
    .i_clock(clk),
    .i_reset(rs),
    .bus    (ifa)
  );

  led_blink_sequencer #(
    .DWELL(1),
    .GAP  (0)
  ) dut_b (
    .i_clock(clk),
    .i_reset(rs),
    .bus    (ifb)
  );

  int dw[2] = '{10, 1};
  int gp[2] = '{2, 0};

  logic       st = 1'b0;
  logic       sp = 1'b0;
  logic       lp = 1'b0;
  logic [7:0] pt = 8'h00;

  // model: 0 idle, 1 active (mp = cycles since start), 2 done
  int         mk[2];
  int         mp[2];
  logic [7:0] mpat[2];
  logic       e_en[2];
  logic [1:0] e_sw[2];
  logic [1:0] e_step[2];
  logic       e_busy[2];
  logic       e_done[2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int busy_a, done_a, busy_b, done_b;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    int seg, ofs, sx, in_s;
    for (int i = 0; i < 2; i++) begin
      e_done[i] = 1'b0;
      if (rs) begin
        mk[i]     = 0;
        mpat[i]   = '0;
        e_en[i]   = 1'b0;
        e_sw[i]   = '0;
        e_step[i] = '0;
        e_busy[i] = 1'b0;
      end else begin
        seg = dw[i] + gp[i];
        case (mk[i])
          0: if (st && !sp) begin
            mk[i]   = 1;
            mp[i]   = 0;
            mpat[i] = pt;
          end
          1: if (sp) begin
            mk[i] = 0;
          end else begin
            ofs  = mp[i] % (4 * seg);
            sx   = ofs / seg;
            in_s = ofs % seg;
            if (sx == 3 && in_s == dw[i] - 1 && !lp)
              mk[i] = 2;
            else
              mp[i]++;
          end
          default: mk[i] = 0;
        endcase
        e_busy[i] = (mk[i] == 1);
        e_done[i] = (mk[i] == 2);
        e_en[i]   = 1'b0;
        if (mk[i] == 1) begin
          ofs       = mp[i] % (4 * seg);
          sx        = ofs / seg;
          in_s      = ofs % seg;
          e_en[i]   = (in_s < dw[i]);
          e_step[i] = sx[1:0];
          e_sw[i]   = mpat[i][2*sx +: 2];
        end
      end
    end
  endtask

  function automatic logic [6:0] exp_of(input int i);
    return {e_en[i], e_sw[i], e_step[i],
            e_busy[i], e_done[i]};
  endfunction

  function automatic logic [6:0] obs_a();
    return {ifa.o_enable, ifa.o_switch_1, ifa.o_switch_2,
            ifa.o_step, ifa.o_busy, ifa.o_done};
  endfunction

  function automatic logic [6:0] obs_b();
    return {ifb.o_enable, ifb.o_switch_1, ifb.o_switch_2,
            ifb.o_step, ifb.o_busy, ifb.o_done};
  endfunction

  task automatic drive();
    ifa.i_start   = st;
    ifa.i_stop    = sp;
    ifa.i_loop    = lp;
    ifa.i_pattern = pt;
    ifb.i_start   = st;
    ifb.i_stop    = sp;
    ifb.i_loop    = lp;
    ifb.i_pattern = pt;
  endtask

  task automatic tick();
    drive();
    model_edge();
    @(negedge clk);
    cyc++;
    check("out_a", 32'(obs_a()), 32'(exp_of(0)));
    check("out_b", 32'(obs_b()), 32'(exp_of(1)));
    busy_a += int'(ifa.o_busy);
    done_a += int'(ifa.o_done);
    busy_b += int'(ifb.o_busy);
    done_b += int'(ifb.o_done);
  endtask

  task automatic clr_counts();
    busy_a = 0;
    done_a = 0;
    busy_b = 0;
    done_b = 0;
  endtask

  task automatic oneshot();
    clr_counts();
    lp = 1'b0;
    pt = 8'b11_10_01_00;
    st = 1'b1;
    tick();
    st = 1'b0;
    for (int i = 1; i < 60; i++) begin
      st = (i == 2 || i == 5);
      pt = 8'($urandom);
      tick();
    end
    st = 1'b0;
    check("busy_a_len", 32'(busy_a), 32'd46);
    check("done_a_cnt", 32'(done_a), 32'd1);
    check("busy_b_len", 32'(busy_b), 32'd4);
    check("done_b_cnt", 32'(done_b), 32'd1);
  endtask

  initial begin
    drive();
    clr_counts();
    tick();
    tick();
    rs = 1'b0;
    tick();

    st = 1'b1;
    sp = 1'b1;
    tick();
    st = 1'b0;
    sp = 1'b0;
    check("idle_pair_busy", 32'(ifa.o_busy), 32'd0);
    tick();

    oneshot();

    clr_counts();
    lp = 1'b1;
    pt = 8'b11_10_01_00;
    st = 1'b1;
    tick();
    st = 1'b0;
    for (int i = 1; i < 70; i++) tick();
    check("loop_nodone", 32'(done_a), 32'd0);
    lp = 1'b0;
    for (int i = 0; i < 200 && done_a == 0; i++) tick();
    check("loop_end_done", 32'(done_a), 32'd1);
    check("loop_end_b", 32'(done_b), 32'd1);
    for (int i = 0; i < 3; i++) tick();

    clr_counts();
    pt = 8'($urandom);
    st = 1'b1;
    tick();
    st = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    sp = 1'b1;
    tick();
    sp = 1'b0;
    check("stop_en", 32'(ifa.o_enable), 32'd0);
    check("stop_busy", 32'(ifa.o_busy), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("stop_nodone", 32'(done_a), 32'd0);
    st = 1'b1;
    tick();
    st = 1'b0;
    check("restart_step", 32'(ifa.o_step), 32'd0);
    check("restart_en", 32'(ifa.o_enable), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("in_gap", 32'(ifa.o_enable), 32'd0);
    #2;
    rs = 1'b1;
    model_edge();
    #1;
    check("async_a", 32'(obs_a()), 32'd0);
    check("async_b", 32'(obs_b()), 32'd0);
    tick();
    rs = 1'b0;
    tick();
    oneshot();

    for (int i = 0; i < 2500; i++) begin
      st = ($urandom_range(0, 15) == 0);
      sp = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 39) == 0) lp = ~lp;
      pt = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
